// File: rtl/kick_check_sequencer.sv
// kick_check_sequencer: serial SRS wall-kick search through one shared collision probe port.
// Tile type 1 is the I piece; orientation encodes 0=spawn, 1=R, 2=180, 3=L.
module kick_check_sequencer #(
    parameter int TEST_POSITIONS = 5,
    parameter int CHECK_LAT      = 1
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_dir,
    input  logic [2:0] req_type,
    input  logic [1:0] req_orientation,
    input  logic [4:0] req_row,
    input  logic [4:0] req_col,
    input  logic       abort,
    output logic       probe_valid,
    output logic [4:0] probe_row,
    output logic [4:0] probe_col,
    output logic [2:0] probe_type,
    output logic [1:0] probe_orientation,
    input  logic       probe_blocked,
    output logic       rsp_valid,
    output logic       rsp_ok,
    output logic [4:0] rsp_row,
    output logic [4:0] rsp_col,
    output logic [2:0] rsp_kick_idx,
    output logic       busy
);
    localparam logic [2:0] TYPE_I = 3'd1;
    typedef enum logic [1:0] {IDLE, PROBE, WAIT, DONE} state_t;

    // The eight SRS tables pair up as negations of four base tables; sel = {base, negate}.
    // Offsets are {row, col} with rows growing downward.
    function automatic logic [9:0] kick_off(input logic is_i, input logic dir,
                                            input logic [1:0] orient, input logic [2:0] k);
        logic [1:0] sel;
        logic [9:0] o;
        sel = 2'b00;
        case ({is_i, dir, orient})
            4'b0000: sel = 2'b11;
            4'b0010: sel = 2'b01;
            4'b0011: sel = 2'b10;
            4'b0100: sel = 2'b01;
            4'b0110: sel = 2'b11;
            4'b0111: sel = 2'b10;
            4'b1000: sel = 2'b11;
            4'b1010: sel = 2'b10;
            4'b1011: sel = 2'b01;
            4'b1100: sel = 2'b01;
            4'b1101: sel = 2'b11;
            4'b1111: sel = 2'b10;
            default: sel = 2'b00;
        endcase
        o = '0;
        case ({is_i, sel[1], k})
            5'b00001: o = {5'(0), 5'(-1)};
            5'b00010: o = {5'(-1), 5'(-1)};
            5'b00011: o = {5'(2), 5'(0)};
            5'b00100: o = {5'(2), 5'(-1)};
            5'b01001: o = {5'(0), 5'(1)};
            5'b01010: o = {5'(-1), 5'(1)};
            5'b01011: o = {5'(2), 5'(0)};
            5'b01100: o = {5'(2), 5'(1)};
            5'b10001: o = {5'(0), 5'(-2)};
            5'b10010: o = {5'(0), 5'(1)};
            5'b10011: o = {5'(1), 5'(-2)};
            5'b10100: o = {5'(-2), 5'(1)};
            5'b11001: o = {5'(0), 5'(-1)};
            5'b11010: o = {5'(0), 5'(2)};
            5'b11011: o = {5'(-2), 5'(-1)};
            5'b11100: o = {5'(1), 5'(2)};
            default:  o = '0;
        endcase
        return sel[0] ? {5'(0) - o[9:5], 5'(0) - o[4:0]} : o;
    endfunction

    state_t     state_q, state_d;
    logic [2:0] k_q, k_d, cnt_q, cnt_d, type_q, type_d, rsp_idx_q, rsp_idx_d;
    logic [1:0] orient_q, orient_d;
    logic [4:0] row_q, row_d, col_q, col_d, rsp_row_q, rsp_row_d, rsp_col_q, rsp_col_d;
    logic       dir_q, dir_d, rsp_ok_q, rsp_ok_d;
    logic [9:0] off;
    logic [4:0] kick_row, kick_col;

    always_comb begin
        off       = kick_off(type_q == TYPE_I, dir_q, orient_q, k_q);
        kick_row  = row_q + off[9:5];
        kick_col  = col_q + off[4:0];
        state_d   = state_q;
        k_d       = k_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        type_d    = type_q;
        orient_d  = orient_q;
        row_d     = row_q;
        col_d     = col_q;
        rsp_ok_d  = rsp_ok_q;
        rsp_row_d = rsp_row_q;
        rsp_col_d = rsp_col_q;
        rsp_idx_d = rsp_idx_q;
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (req_valid) begin
                    dir_d    = req_dir;
                    type_d   = req_type;
                    orient_d = req_orientation;
                    row_d    = req_row;
                    col_d    = req_col;
                    k_d      = '0;
                    state_d  = PROBE;
                end
                PROBE: begin
                    cnt_d   = 3'(CHECK_LAT - 1);
                    state_d = WAIT;
                end
                WAIT: if (cnt_q != '0) begin
                    cnt_d = cnt_q - 3'd1;
                end else if (!probe_blocked) begin
                    rsp_ok_d  = 1'b1;
                    rsp_row_d = kick_row;
                    rsp_col_d = kick_col;
                    rsp_idx_d = k_q;
                    state_d   = DONE;
                end else if (k_q == 3'(TEST_POSITIONS - 1)) begin
                    rsp_ok_d  = 1'b0;
                    rsp_row_d = row_q;
                    rsp_col_d = col_q;
                    rsp_idx_d = '0;
                    state_d   = DONE;
                end else begin
                    k_d     = k_q + 3'd1;
                    state_d = PROBE;
                end
                DONE: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q   <= IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            dir_q     <= 1'b0;
            type_q    <= '0;
            orient_q  <= '0;
            row_q     <= '0;
            col_q     <= '0;
            rsp_ok_q  <= 1'b0;
            rsp_row_q <= '0;
            rsp_col_q <= '0;
            rsp_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            dir_q     <= dir_d;
            type_q    <= type_d;
            orient_q  <= orient_d;
            row_q     <= row_d;
            col_q     <= col_d;
            rsp_ok_q  <= rsp_ok_d;
            rsp_row_q <= rsp_row_d;
            rsp_col_q <= rsp_col_d;
            rsp_idx_q <= rsp_idx_d;
        end
    end

    assign req_ready         = state_q == IDLE;
    assign busy              = state_q != IDLE;
    assign probe_valid       = state_q == PROBE;
    assign rsp_valid         = state_q == DONE;
    assign probe_row         = kick_row;
    assign probe_col         = kick_col;
    assign probe_type        = type_q;
    assign probe_orientation = orient_q;
    assign rsp_ok            = rsp_ok_q;
    assign rsp_row           = rsp_row_q;
    assign rsp_col           = rsp_col_q;
    assign rsp_kick_idx      = rsp_idx_q;
endmodule

// File: tb/tb_kick_check_sequencer.sv
// tb_kick_check_sequencer: directed kick-table vectors on a CHECK_LAT=1 instance,
// plus an all-blocked I-piece run on a CHECK_LAT=2 instance and abort/hold/reset sequences.
module tb_kick_check_sequencer;
    logic clk = 1'b0;
    logic rst_l = 1'b0;
    always #5 clk = ~clk;

    logic       req_valid = 1'b0, req_dir = 1'b0, abort = 1'b0;
    logic [2:0] req_type = '0;
    logic [1:0] req_orientation = '0;
    logic [4:0] req_row = '0, req_col = '0;

    logic       rdy1, pv1, pb1, rv1, ok1, busy1;
    logic [4:0] pr1, pc1, rr1, rc1;
    logic [2:0] pt1, ri1;
    logic [1:0] po1;
    logic       rdy2, pv2, pb2, rv2, ok2, busy2;
    logic [4:0] pr2, pc2, rr2, rc2;
    logic [2:0] pt2, ri2;
    logic [1:0] po2;

    kick_check_sequencer #(.TEST_POSITIONS(5), .CHECK_LAT(1)) u1 (
        .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_ready(rdy1), .req_dir(req_dir),
        .req_type(req_type), .req_orientation(req_orientation), .req_row(req_row), .req_col(req_col),
        .abort(abort), .probe_valid(pv1), .probe_row(pr1), .probe_col(pc1), .probe_type(pt1),
        .probe_orientation(po1), .probe_blocked(pb1), .rsp_valid(rv1), .rsp_ok(ok1),
        .rsp_row(rr1), .rsp_col(rc1), .rsp_kick_idx(ri1), .busy(busy1));

    kick_check_sequencer #(.TEST_POSITIONS(5), .CHECK_LAT(2)) u2 (
        .clk(clk), .rst_l(rst_l), .req_valid(req_valid), .req_ready(rdy2), .req_dir(req_dir),
        .req_type(req_type), .req_orientation(req_orientation), .req_row(req_row), .req_col(req_col),
        .abort(abort), .probe_valid(pv2), .probe_row(pr2), .probe_col(pc2), .probe_type(pt2),
        .probe_orientation(po2), .probe_blocked(pb2), .rsp_valid(rv2), .rsp_ok(ok2),
        .rsp_row(rr2), .rsp_col(rc2), .rsp_kick_idx(ri2), .busy(busy2));

    // Collision checker models: probe n of a request is blocked when mask[n] is set;
    // the answer is only presented exactly CHECK_LAT cycles after the probe.
    logic [7:0] mask = '0;
    logic [2:0] pn1 = '0, pn2 = '0;
    logic       s2 = 1'b0;
    initial pb1 = 1'b0;
    initial pb2 = 1'b0;
    always @(posedge clk) begin
        pn1 <= (req_valid && rdy1) ? 3'd0 : pv1 ? pn1 + 3'd1 : pn1;
        pb1 <= pv1 ? mask[pn1] : 1'b0;
        pn2 <= (req_valid && rdy2) ? 3'd0 : pv2 ? pn2 + 3'd1 : pn2;
        s2  <= pv2 ? mask[pn2] : 1'b0;
        pb2 <= s2;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] ty, input logic dir, input logic [1:0] ori,
                         input logic [4:0] row, input logic [4:0] col, output int c0);
        @(negedge clk);
        req_type = ty; req_dir = dir; req_orientation = ori; req_row = row; req_col = col;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int c0, output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            if (rv1) begin
                lat = cyc - c0 + 1;
                return;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        logic [2:0] ty; logic dir; logic [1:0] ori; logic [4:0] row, col; logic [7:0] m;
        logic ok; logic [4:0] er, ec; logic [2:0] ei; int lat;
    } vec_t;
    vec_t v[12];

    int c0, lat, np, rlat;
    int plat[5], prow[5], pcol[5];
    int exp_pr[5] = '{10, 10, 10, 11, 8};
    int exp_pc[5] = '{10, 8, 11, 8, 11};

    initial begin
        v[0]  = '{3'd3, 1'b0, 2'd1, 5'd5,  5'd4,  8'h00, 1'b1, 5'd5,  5'd4,  3'd0, 3};
        v[1]  = '{3'd3, 1'b0, 2'd1, 5'd5,  5'd4,  8'h01, 1'b1, 5'd5,  5'd3,  3'd1, 5};
        v[2]  = '{3'd3, 1'b0, 2'd0, 5'd10, 5'd10, 8'h03, 1'b1, 5'd11, 5'd9,  3'd2, 7};
        v[3]  = '{3'd3, 1'b1, 2'd2, 5'd10, 5'd10, 8'h07, 1'b1, 5'd8,  5'd10, 3'd3, 9};
        v[4]  = '{3'd3, 1'b1, 2'd3, 5'd10, 5'd10, 8'h0F, 1'b1, 5'd12, 5'd11, 3'd4, 11};
        v[5]  = '{3'd1, 1'b0, 2'd1, 5'd10, 5'd10, 8'h01, 1'b1, 5'd10, 5'd8,  3'd1, 5};
        v[6]  = '{3'd1, 1'b1, 2'd0, 5'd10, 5'd10, 8'h07, 1'b1, 5'd9,  5'd12, 3'd3, 9};
        v[7]  = '{3'd1, 1'b0, 2'd2, 5'd10, 5'd10, 8'h0F, 1'b1, 5'd11, 5'd12, 3'd4, 11};
        v[8]  = '{3'd1, 1'b1, 2'd1, 5'd10, 5'd10, 8'h03, 1'b1, 5'd10, 5'd8,  3'd2, 7};
        v[9]  = '{3'd3, 1'b0, 2'd1, 5'd10, 5'd10, 8'h1F, 1'b0, 5'd10, 5'd10, 3'd0, 11};
        v[10] = '{3'd3, 1'b0, 2'd1, 5'd0,  5'd0,  8'h01, 1'b1, 5'd0,  5'd31, 3'd1, 5};
        v[11] = '{3'd3, 1'b0, 2'd1, 5'd30, 5'd0,  8'h07, 1'b1, 5'd0,  5'd0,  3'd3, 9};

        #12;
        chk("reset req_ready", int'(rdy1), 1);
        chk("reset busy", int'(busy1), 0);
        chk("reset probe_valid", int'(pv1), 0);
        chk("reset rsp_valid", int'(rv1), 0);
        chk("reset rsp_ok", int'(ok1), 0);
        chk("reset probe_row", int'(pr1), 0);
        @(negedge clk);
        rst_l = 1'b1;

        // I piece, CW to R, every kick blocked, CHECK_LAT=2
        mask = 8'h1F;
        issue(3'd1, 1'b0, 2'd1, 5'd10, 5'd10, c0);
        np = 0; rlat = -1;
        for (int i = 0; i < 40 && rlat < 0; i++) begin
            if (pv2 && np < 5) begin
                plat[np] = cyc - c0 + 1; prow[np] = int'(pr2); pcol[np] = int'(pc2);
                np++;
            end
            if (rv2) rlat = cyc - c0 + 1;
            else @(negedge clk);
        end
        chk("I probe count", np, 5);
        for (int j = 0; j < np; j++) begin
            chk($sformatf("I probe%0d cycle", j), plat[j], 1 + 3 * j);
            chk($sformatf("I probe%0d row", j), prow[j], exp_pr[j]);
            chk($sformatf("I probe%0d col", j), pcol[j], exp_pc[j]);
        end
        chk("I rsp cycle", rlat, 16);
        chk("I rsp ok", int'(ok2), 0);
        chk("I rsp row", int'(rr2), 10);
        chk("I rsp col", int'(rc2), 10);
        chk("I rsp idx", int'(ri2), 0);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            mask = v[i].m;
            chk($sformatf("v%0d ready", i), int'(rdy1), 1);
            issue(v[i].ty, v[i].dir, v[i].ori, v[i].row, v[i].col, c0);
            wait_rsp(c0, lat);
            chk($sformatf("v%0d latency", i), lat, v[i].lat);
            chk($sformatf("v%0d ok", i), int'(ok1), int'(v[i].ok));
            chk($sformatf("v%0d row", i), int'(rr1), int'(v[i].er));
            chk($sformatf("v%0d col", i), int'(rc1), int'(v[i].ec));
            chk($sformatf("v%0d idx", i), int'(ri1), int'(v[i].ei));
            @(negedge clk);
            chk($sformatf("v%0d rsp pulse", i), int'(rv1), 0);
            chk($sformatf("v%0d idle", i), int'(busy1), 0);
            repeat (4) @(negedge clk);
        end

        // abort during the WAIT of kick 2
        mask = 8'h1F;
        issue(3'd3, 1'b0, 2'd1, 5'd10, 5'd10, c0);
        for (int i = 0; i < 20 && cyc - c0 < 5; i++) @(negedge clk);
        chk("abort in wait busy", int'(busy1), 1);
        chk("abort in wait no probe", int'(pv1), 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort busy", int'(busy1), 0);
        chk("abort ready", int'(rdy1), 1);
        np = 0;
        for (int i = 0; i < 10; i++) begin
            np += int'(rv1) + int'(pv1);
            @(negedge clk);
        end
        chk("abort quiet", np, 0);
        // request with abort held in IDLE is still accepted
        mask = 8'h00;
        abort = 1'b1;
        issue(3'd3, 1'b0, 2'd1, 5'd7, 5'd7, c0);
        abort = 1'b0;
        wait_rsp(c0, lat);
        chk("post-abort latency", lat, 3);
        chk("post-abort ok", int'(ok1), 1);
        chk("post-abort row", int'(rr1), 7);
        chk("post-abort col", int'(rc1), 7);
        repeat (4) @(negedge clk);

        // req_valid held through a sequence with fields changed after accept
        mask = 8'h01;
        req_type = 3'd3; req_dir = 1'b0; req_orientation = 2'd1; req_row = 5'd5; req_col = 5'd4;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        req_orientation = 2'd2; req_row = 5'd20; req_col = 5'd20;
        rlat = -1; lat = -1;
        for (int i = 0; i < 30 && rlat < 0; i++) begin
            if (rv1) begin
                lat = cyc - c0 + 1;
                chk("held A row", int'(rr1), 5);
                chk("held A col", int'(rc1), 3);
            end
            if (rdy1) rlat = cyc - c0 + 1;
            else @(negedge clk);
        end
        chk("held A latency", lat, 5);
        chk("held B ready cycle", rlat, 6);
        @(posedge clk);
        @(negedge clk);
        c0 = cyc;
        req_valid = 1'b0;
        wait_rsp(c0, lat);
        chk("held B latency", lat, 5);
        chk("held B ok", int'(ok1), 1);
        chk("held B row", int'(rr1), 20);
        chk("held B col", int'(rc1), 21);
        chk("held B idx", int'(ri1), 1);
        repeat (4) @(negedge clk);

        // asynchronous reset in the WAIT of kick 1
        mask = 8'h1F;
        issue(3'd3, 1'b0, 2'd1, 5'd10, 5'd10, c0);
        for (int i = 0; i < 20 && cyc - c0 < 3; i++) @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        chk("async rst ready", int'(rdy1), 1);
        chk("async rst busy", int'(busy1), 0);
        chk("async rst probe", int'(pv1), 0);
        chk("async rst rsp_row", int'(rr1), 0);
        chk("async rst rsp_col", int'(rc1), 0);
        chk("async rst rsp_idx", int'(ri1), 0);
        @(negedge clk);
        rst_l = 1'b1;
        np = 0;
        for (int i = 0; i < 12; i++) begin
            np += int'(rv1) + int'(pv1);
            @(negedge clk);
        end
        chk("post-reset quiet", np, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/kick_check_sequencer.md
Name: kick_check_sequencer

Overview:
Sequences the serial SRS wall-kick test for one rotation request at a time through a single shared collision-check port. Downstream of that port sits a registered occupancy checker that compares four rendered tiles against locked_state. The sequencer adds each kick offset to the requested origin in order, issues one probe per kick, and stops at the first unblocked position. It returns valid/ok plus the kicked origin and kick index to the game FSM. An abort input discards stale work when locked_state or the falling piece changes.

Parameters:
TEST_POSITIONS, 5, number of kick offsets tried per rotation (indices 0..TEST_POSITIONS-1)
CHECK_LAT, 1, cycles from probe_valid to probe_blocked being valid; legal range 1..4

Ports:
clk  input  1  clock
rst_l  input  1  asynchronous active-low reset
req_valid  input  1  rotation request present
req_ready  output  1  sequencer can accept a request (state IDLE)
req_dir  input  1  0 = rotate right (CW), 1 = rotate left (CCW)
req_type  input  tile_type_t  falling tetromino type; I selects the WK_I_* tables
req_orientation  input  orientation_t  target orientation after rotation
req_row  input  5  unkicked origin row
req_col  input  5  unkicked origin col
abort  input  1  cancel in-flight request
probe_valid  output  1  one-cycle probe strobe to the collision checker
probe_row  output  5  kicked origin row
probe_col  output  5  kicked origin col
probe_type  output  tile_type_t  latched req_type
probe_orientation  output  orientation_t  latched req_orientation
probe_blocked  input  1  1 = any tile is out of bounds or overlaps a non-BLANK cell; sampled CHECK_LAT cycles after the probe
rsp_valid  output  1  one-cycle result pulse
rsp_ok  output  1  1 = some kick position is free
rsp_row  output  5  kicked row if ok, else the unkicked req_row
rsp_col  output  5  kicked col if ok, else the unkicked req_col
rsp_kick_idx  output  3  index of the winning kick; 0 when not ok
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_l low): state IDLE, kick index 0, wait counter 0. All outputs 0 except req_ready=1.
- States: IDLE, PROBE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid, latch dir/type/orientation/row/col, set k=0, go to PROBE.
- PROBE (one cycle):
  - probe_valid=1, with probe_row = req_row + 5'(row offset), probe_col = req_col + 5'(col offset). Addition is 5-bit two's-complement wrap; out-of-range results are left for the checker to reject.
  - Offset table is selected by dir, target orientation and (type==I). Dir R with target 0/R/2/L uses L0/0R/R2/2L. Dir L with target 0/R/2/L uses R0/2R/L2/0L.
  - Load wait counter with CHECK_LAT-1, go to WAIT.
- WAIT: decrement the counter each cycle. When it is 0, sample probe_blocked:
  - not blocked: rsp_ok=1, capture the kicked row/col and kick index k, go to DONE;
  - blocked with k<TEST_POSITIONS-1: k++, go to PROBE;
  - blocked with k==TEST_POSITIONS-1: rsp_ok=0, rsp_row/rsp_col = unkicked origin, kick index 0, go to DONE.
- DONE (one cycle): rsp_valid=1, then IDLE. rsp_ok/row/col/kick_idx hold their values until the next rsp_valid.
- Latency: success at kick k gives rsp_valid k*(CHECK_LAT+1)+CHECK_LAT+2 cycles after the accept edge. CHECK_LAT=1, k=0: accept at cycle 0, probe at cycle 1, sample at cycle 2, rsp_valid at cycle 3.
- abort in PROBE, WAIT or DONE: go to IDLE next cycle with no rsp_valid; a late probe_blocked is ignored.
- abort in IDLE: no effect. Simultaneous abort and req_valid in IDLE: request is accepted.
- req_valid while busy: ignored (req_ready=0). The requester holds req_valid until it sees req_ready.
- Reset asserted mid-sequence: immediate return to IDLE, outputs cleared.

Test Plan:
- Non-I, dir R, target R, row 5 col 4, probe_blocked always 0 -> one probe at (5,4); rsp_valid at cycle 3 with ok=1, (5,4), idx 0.
- Non-I, dir R, target R, row 5 col 4, kick 0 blocked, kick 1 free -> second probe at col 3 (WK_NON_I_0R[1] = col -1, row 0); rsp ok=1, (5,3), idx 1, rsp_valid at cycle 5.
- I piece, all kicks blocked, CHECK_LAT=2 -> 5 probes each 3 cycles apart, offsets per WK_I table; rsp ok=0, row/col = request, idx 0, rsp_valid at cycle 16.
- abort during the WAIT of kick 2 -> no rsp_valid; busy=0 next cycle; a new request is then accepted and completes normally.
- req_valid held high during a sequence -> second request accepted only on the cycle after rsp_valid, with its own latched fields.
- rst_l pulsed low mid-WAIT -> outputs 0, req_ready=1 asynchronously; no probe_valid or rsp_valid follows.
